vga_fb_write_ctrl: RTL and testbench

- Owns the write port of the 160x120 one-bit frame buffer (dual-port RAM; the VGA signal generator reads the other port).
- Arbitrates each cycle between a processor write requester and an internal fill engine that clears or floods the whole frame.
- Holds the live foreground/background colour word and changes it only at frame start, so the display never tears mid-frame.

---
 rtl/vga_fb_pkg.sv | 31 +++
 rtl/fb_raster_counter.sv | 52 +++++
 rtl/vga_fb_write_ctrl.sv | 149 ++++++++++++++
 tb/tb_vga_fb_write_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// ============================================================================
// Module   : vga_fb_pkg
// Brief    : Shared frame-buffer geometry, address packing and fill states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_fb_pkg;

    localparam int FB_W   = 160;
    localparam int FB_H   = 120;
    localparam int X_W    = 8;
    localparam int Y_W    = 7;
    localparam int ADDR_W = X_W + Y_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_FILLING = 2'd2,
        ST_DONE    = 2'd3
    } fill_state_t;

    // Same {y, x} packing the VGA signal generator uses on the read port.
    function automatic logic [ADDR_W-1:0] fb_addr_pack(input logic [Y_W-1:0] y,
                                                       input logic [X_W-1:0] x);
        return {y, x};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fb_raster_counter.sv
// ============================================================================
// Module   : fb_raster_counter
// Brief    : Raster x/y counter with enable, clear and last-pixel flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_raster_counter
    import vga_fb_pkg::*;
#(
    parameter int FB_W = vga_fb_pkg::FB_W,
    parameter int FB_H = vga_fb_pkg::FB_H
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_en,
    input  logic           i_clr,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_last
);

    localparam logic [X_W-1:0] c_x_last = X_W'(FB_W - 1);
    localparam logic [Y_W-1:0] c_y_last = Y_W'(FB_H - 1);

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_en) begin
            if (r_x == c_x_last) begin
                r_x <= '0;
                r_y <= (r_y == c_y_last) ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = (r_x == c_x_last) && (r_y == c_y_last);

endmodule

`default_nettype wire

// File: rtl/vga_fb_write_ctrl.sv
// ============================================================================
// Module   : vga_fb_write_ctrl
// Brief    : Frame-buffer write-port arbiter (CPU vs. fill) and colour latch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_fb_write_ctrl
    import vga_fb_pkg::*;
#(
    parameter int          FB_W          = vga_fb_pkg::FB_W,
    parameter int          FB_H          = vga_fb_pkg::FB_H,
    parameter bit          FILL_SYNC     = 1'b1,
    parameter logic [15:0] RESET_COLOURS = 16'hFF00
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              VGA_VS,
    input  logic              CPU_REQ,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic              CPU_DATA,
    output logic              CPU_ACK,
    input  logic              FILL_START,
    input  logic              FILL_VALUE,
    output logic              FILL_BUSY,
    output logic              FILL_DONE,
    input  logic              COLOUR_WE,
    input  logic [15:0]       COLOUR_IN,
    output logic              FB_WE,
    output logic [ADDR_W-1:0] FB_ADDR,
    output logic              FB_DATA,
    output logic [15:0]       CONFIG_COLOURS
);

    localparam logic [X_W-1:0] c_x_last = X_W'(FB_W - 1);
    localparam logic [Y_W-1:0] c_y_last = Y_W'(FB_H - 1);

    fill_state_t    r_state;
    logic           r_fill_value;
    logic           r_vs_d;
    logic [15:0]    r_pend_colours;
    logic           r_pend_valid;

    logic           w_frame_start;
    logic           w_cpu_accept;
    logic           w_cpu_in_range;
    logic           w_fill_grant;
    logic           w_cnt_clr;
    logic [X_W-1:0] w_x;
    logic [Y_W-1:0] w_y;
    logic           w_last;

    assign w_frame_start  = r_vs_d & ~VGA_VS;
    // CPU_ACK high blocks acceptance, which leaves every other slot to the fill.
    assign w_cpu_accept   = CPU_REQ & ~CPU_ACK;
    assign w_cpu_in_range = (CPU_ADDR[X_W-1:0] <= c_x_last) &&
                            (CPU_ADDR[ADDR_W-1:X_W] <= c_y_last);
    assign w_fill_grant   = (r_state == ST_FILLING) & ~w_cpu_accept;
    assign w_cnt_clr      = (r_state == ST_IDLE) & FILL_START;

    fb_raster_counter #(
        .FB_W (FB_W),
        .FB_H (FB_H)
    ) u_raster (
        .clk    (CLK),
        .rst    (RESET),
        .i_en   (w_fill_grant),
        .i_clr  (w_cnt_clr),
        .o_x    (w_x),
        .o_y    (w_y),
        .o_last (w_last)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_fill_value <= 1'b0;
            CPU_ACK      <= 1'b0;
            FILL_BUSY    <= 1'b0;
            FILL_DONE    <= 1'b0;
            FB_WE        <= 1'b0;
            FB_ADDR      <= '0;
            FB_DATA      <= 1'b0;
        end else begin
            CPU_ACK   <= w_cpu_accept;
            FILL_DONE <= 1'b0;
            FB_WE     <= 1'b0;

            if (w_cpu_accept) begin
                FB_WE   <= w_cpu_in_range;
                FB_ADDR <= CPU_ADDR;
                FB_DATA <= CPU_DATA;
            end else if (w_fill_grant) begin
                FB_WE   <= 1'b1;
                FB_ADDR <= fb_addr_pack(w_y, w_x);
                FB_DATA <= r_fill_value;
            end

            case (r_state)
                ST_IDLE: begin
                    if (FILL_START) begin
                        r_fill_value <= FILL_VALUE;
                        FILL_BUSY    <= 1'b1;
                        r_state      <= FILL_SYNC ? ST_ARMED : ST_FILLING;
                    end
                end
                ST_ARMED: begin
                    if (w_frame_start) begin
                        r_state <= ST_FILLING;
                    end
                end
                ST_FILLING: begin
                    if (w_fill_grant && w_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    FILL_DONE <= 1'b1;
                    FILL_BUSY <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A write coinciding with frame start stays pending for the following frame.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_vs_d         <= 1'b1;
            r_pend_colours <= '0;
            r_pend_valid   <= 1'b0;
            CONFIG_COLOURS <= RESET_COLOURS;
        end else begin
            r_vs_d <= VGA_VS;
            if (w_frame_start && r_pend_valid) begin
                CONFIG_COLOURS <= r_pend_colours;
                r_pend_valid   <= 1'b0;
            end
            if (COLOUR_WE) begin
                r_pend_colours <= COLOUR_IN;
                r_pend_valid   <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_write_ctrl.sv
// ============================================================================
// Module   : tb_vga_fb_write_ctrl
// Brief    : Directed bench; instance 0 starts fills immediately, 1 at frame start.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_fb_write_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vga_vs = 1'b1;
    logic        cpu_req = 1'b0;
    logic [14:0] cpu_addr = '0;
    logic        cpu_data = 1'b0;
    logic        fill_start0 = 1'b0;
    logic        fill_start1 = 1'b0;
    logic        fill_value = 1'b0;
    logic        colour_we = 1'b0;
    logic [15:0] colour_in = '0;

    logic        cpu_ack0, fill_busy0, fill_done0, fb_we0, fb_data0;
    logic [14:0] fb_addr0;
    logic [15:0] config0;
    logic        cpu_ack1, fill_busy1, fill_done1, fb_we1, fb_data1;
    logic [14:0] fb_addr1;
    logic [15:0] config1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vga_fb_write_ctrl #(
        .FB_W(160), .FB_H(120), .FILL_SYNC(1'b0), .RESET_COLOURS(16'hFF00)
    ) u_dut0 (
        .CLK(clk), .RESET(rst), .VGA_VS(vga_vs),
        .CPU_REQ(cpu_req), .CPU_ADDR(cpu_addr), .CPU_DATA(cpu_data), .CPU_ACK(cpu_ack0),
        .FILL_START(fill_start0), .FILL_VALUE(fill_value),
        .FILL_BUSY(fill_busy0), .FILL_DONE(fill_done0),
        .COLOUR_WE(colour_we), .COLOUR_IN(colour_in),
        .FB_WE(fb_we0), .FB_ADDR(fb_addr0), .FB_DATA(fb_data0),
        .CONFIG_COLOURS(config0)
    );

    vga_fb_write_ctrl #(
        .FB_W(160), .FB_H(120), .FILL_SYNC(1'b1), .RESET_COLOURS(16'hFF00)
    ) u_dut1 (
        .CLK(clk), .RESET(rst), .VGA_VS(vga_vs),
        .CPU_REQ(cpu_req), .CPU_ADDR(cpu_addr), .CPU_DATA(cpu_data), .CPU_ACK(cpu_ack1),
        .FILL_START(fill_start1), .FILL_VALUE(fill_value),
        .FILL_BUSY(fill_busy1), .FILL_DONE(fill_done1),
        .COLOUR_WE(colour_we), .COLOUR_IN(colour_in),
        .FB_WE(fb_we1), .FB_ADDR(fb_addr1), .FB_DATA(fb_data1),
        .CONFIG_COLOURS(config1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++;
        if ({fb_we0, fb_addr0, fb_data0, cpu_ack0, fill_busy0, fill_done0} !== 20'h0) begin
            bad++;
            $display("FAIL reset_outputs: got we=%b addr=%h data=%b ack=%b busy=%b done=%b, want all 0",
                     fb_we0, fb_addr0, fb_data0, cpu_ack0, fill_busy0, fill_done0);
        end
        total++;
        if (config0 !== 16'hFF00) begin
            bad++;
            $display("FAIL reset_colours: got %h want ff00", config0);
        end
    endtask

    task automatic test_cpu_write();
        cpu_req  = 1'b1;
        cpu_addr = {7'd5, 8'd10};
        cpu_data = 1'b1;
        tick();
        total++;
        if ({cpu_ack0, fb_we0, fb_addr0, fb_data0} !== {1'b1, 1'b1, 15'h050A, 1'b1}) begin
            bad++;
            $display("FAIL cpu_write1: got ack=%b we=%b addr=%h data=%b, want 1 1 050a 1",
                     cpu_ack0, fb_we0, fb_addr0, fb_data0);
        end
        tick();
        total++;
        if ({cpu_ack0, fb_we0} !== 2'b00) begin
            bad++;
            $display("FAIL cpu_turnaround: got ack=%b we=%b, want 0 0", cpu_ack0, fb_we0);
        end
        tick();
        cpu_req = 1'b0;
        total++;
        if ({cpu_ack0, fb_we0, fb_addr0} !== {1'b1, 1'b1, 15'h050A}) begin
            bad++;
            $display("FAIL cpu_write2: got ack=%b we=%b addr=%h, want 1 1 050a",
                     cpu_ack0, fb_we0, fb_addr0);
        end
        tick();
        total++;
        if (cpu_ack0 !== 1'b0) begin
            bad++;
            $display("FAIL cpu_idle: got ack=%b want 0", cpu_ack0);
        end
    endtask

    task automatic test_cpu_range();
        cpu_req  = 1'b1;
        cpu_addr = {7'd0, 8'd160};
        tick();
        cpu_req = 1'b0;
        total++;
        if ({cpu_ack0, fb_we0} !== 2'b10) begin
            bad++;
            $display("FAIL cpu_x_oob: got ack=%b we=%b, want 1 0", cpu_ack0, fb_we0);
        end
        tick();
        cpu_req  = 1'b1;
        cpu_addr = {7'd120, 8'd0};
        tick();
        cpu_req = 1'b0;
        total++;
        if ({cpu_ack0, fb_we0} !== 2'b10) begin
            bad++;
            $display("FAIL cpu_y_oob: got ack=%b we=%b, want 1 0", cpu_ack0, fb_we0);
        end
        tick();
    endtask

    task automatic test_fill_nosync();
        int errs = 0;
        int first_bad = -1;
        logic [14:0] exp_addr;
        int done_cnt = 0;
        fill_value  = 1'b0;
        fill_start0 = 1'b1;
        tick();
        fill_start0 = 1'b0;
        for (int i = 0; i < 19200; i++) begin
            tick();
            exp_addr = {7'(i / 160), 8'(i % 160)};
            if (fb_we0 !== 1'b1 || fb_addr0 !== exp_addr || fb_data0 !== 1'b0 ||
                fill_done0 !== 1'b0 || fill_busy0 !== 1'b1) begin
                errs++;
                if (first_bad < 0) first_bad = i;
            end
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL fill_seq: %0d bad cycles, first at write %0d, want 0", errs, first_bad);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (fill_done0 === 1'b1) done_cnt++;
        end
        total++;
        if (done_cnt != 1 || fill_busy0 !== 1'b0 || fb_we0 !== 1'b0) begin
            bad++;
            $display("FAIL fill_done: got pulses=%0d busy=%b we=%b, want 1 0 0",
                     done_cnt, fill_busy0, fb_we0);
        end
    endtask

    task automatic test_fill_with_cpu();
        int fill_n = 0;
        int cpu_n = 0;
        int errs = 0;
        int cyc = 0;
        int last_cyc = -1;
        bit done_seen = 1'b0;
        logic [14:0] exp_addr;
        fill_value  = 1'b1;
        fill_start0 = 1'b1;
        tick();
        fill_start0 = 1'b0;
        cpu_req  = 1'b1;
        cpu_addr = {7'd3, 8'd3};
        cpu_data = 1'b0;
        while (!done_seen && cyc < 40000) begin
            if (fill_n == 5000) begin
                fill_start0 = 1'b1;
                fill_value  = 1'b0;
            end else begin
                fill_start0 = 1'b0;
            end
            tick();
            cyc++;
            if (fill_done0 === 1'b1) done_seen = 1'b1;
            if (cpu_ack0 === 1'b1) begin
                cpu_n++;
                if (fb_we0 !== 1'b1 || fb_addr0 !== 15'h0303 || fb_data0 !== 1'b0) errs++;
            end else if (fb_we0 === 1'b1) begin
                exp_addr = {7'(fill_n / 160), 8'(fill_n % 160)};
                if (fb_addr0 !== exp_addr || fb_data0 !== 1'b1) errs++;
                fill_n++;
                if (fill_n == 19200) last_cyc = cyc;
            end
        end
        fill_start0 = 1'b0;
        cpu_req = 1'b0;
        tick();
        tick();
        total++;
        if (!done_seen) begin
            bad++;
            $display("FAIL fill_cpu_timeout: no FILL_DONE within %0d cycles", cyc);
        end
        total++;
        if (errs != 0 || fill_n != 19200) begin
            bad++;
            $display("FAIL fill_cpu_seq: got errs=%0d fill_writes=%0d, want 0 19200", errs, fill_n);
        end
        total++;
        if (last_cyc != 38400) begin
            bad++;
            $display("FAIL fill_cpu_time: got last fill write at cycle %0d want 38400", last_cyc);
        end
        total++;
        if (cpu_n < 19200 || cpu_n > 19201) begin
            bad++;
            $display("FAIL fill_cpu_acks: got %0d cpu writes want 19200..19201", cpu_n);
        end
    endtask

    task automatic test_fill_sync();
        int early = 0;
        fill_value  = 1'b1;
        fill_start1 = 1'b1;
        tick();
        fill_start1 = 1'b0;
        total++;
        if ({fill_busy1, fb_we1} !== 2'b10) begin
            bad++;
            $display("FAIL sync_armed: got busy=%b we=%b, want 1 0", fill_busy1, fb_we1);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (fb_we1 !== 1'b0) early++;
        end
        vga_vs = 1'b0;
        tick();
        if (fb_we1 !== 1'b0) early++;
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL sync_wait: got %0d writes before frame start want 0", early);
        end
        tick();
        total++;
        if ({fb_we1, fb_addr1, fb_data1} !== {1'b1, 15'h0000, 1'b1}) begin
            bad++;
            $display("FAIL sync_first: got we=%b addr=%h data=%b, want 1 0000 1",
                     fb_we1, fb_addr1, fb_data1);
        end
        vga_vs = 1'b1;
        tick();
    endtask

    task automatic test_colour();
        colour_we = 1'b1;
        colour_in = 16'h1C03;
        tick();
        colour_in = 16'hE0FF;
        tick();
        colour_we = 1'b0;
        tick();
        total++;
        if (config0 !== 16'hFF00) begin
            bad++;
            $display("FAIL colour_hold: got %h want ff00", config0);
        end
        vga_vs = 1'b0;
        tick();
        total++;
        if (config0 !== 16'hE0FF) begin
            bad++;
            $display("FAIL colour_apply: got %h want e0ff", config0);
        end
        vga_vs = 1'b1;
        tick();
        colour_we = 1'b1;
        colour_in = 16'h1234;
        vga_vs    = 1'b0;
        tick();
        colour_we = 1'b0;
        vga_vs    = 1'b1;
        tick();
        total++;
        if (config0 !== 16'hE0FF) begin
            bad++;
            $display("FAIL colour_same_cycle: got %h want e0ff", config0);
        end
        vga_vs = 1'b0;
        tick();
        vga_vs = 1'b1;
        total++;
        if (config0 !== 16'h1234) begin
            bad++;
            $display("FAIL colour_next_frame: got %h want 1234", config0);
        end
        tick();
    endtask

    task automatic test_reset_mid_fill();
        int done_cnt = 0;
        total++;
        if (fill_busy1 !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_busy: got %b want 1", fill_busy1);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({fb_we1, fb_addr1, fb_data1, cpu_ack1, fill_busy1, fill_done1} !== 20'h0 ||
            config1 !== 16'hFF00 || config0 !== 16'hFF00) begin
            bad++;
            $display("FAIL async_reset: got we=%b addr=%h busy=%b cfg1=%h cfg0=%h, want 0 0000 0 ff00 ff00",
                     fb_we1, fb_addr1, fill_busy1, config1, config0);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (fill_done1 === 1'b1 || fill_busy1 === 1'b1 || fb_we1 === 1'b1) done_cnt++;
        end
        total++;
        if (done_cnt != 0) begin
            bad++;
            $display("FAIL reset_abort: got %0d cycles with done/busy/we after reset want 0", done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_cpu_range();
        test_fill_nosync();
        test_fill_with_cpu();
        test_fill_sync();
        test_colour();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
